// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and defaults for the instruction fetch controller
package fetch_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_sat_cnt.sv
// rtl/fetch_sat_cnt.sv - saturating event counter with synchronous clear
module fetch_sat_cnt
   import fetch_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // count events, clear wins over increment, hold at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - sequential instruction fetch FSM; FETCH_PERF_CNT_EN enables fetch_count
module instr_fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              halt_req,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              busy,
   output logic              done,
   output logic [15:0]       fetch_count
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_halt_pending;
   logic              r_imem_req;
   logic [ADDR_W-1:0] r_imem_addr;
   logic              r_instr_valid;
   logic [DATA_W-1:0] r_instr_out;
   logic [ADDR_W-1:0] r_instr_addr;
   logic              r_busy;
   logic              r_done;

   // fetch sequencing: request, hold the word for downstream, then pick next pc or finish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_pc           <= '0;
         r_halt_pending <= 1'b0;
         r_imem_req     <= 1'b0;
         r_imem_addr    <= '0;
         r_instr_valid  <= 1'b0;
         r_instr_out    <= '0;
         r_instr_addr   <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_pc           <= start_addr;
                  r_halt_pending <= 1'b0;
                  r_imem_req     <= 1'b1;
                  r_imem_addr    <= start_addr;
                  r_busy         <= 1'b1;
                  r_state        <= REQ;
               end
            end
            REQ: begin
               if (halt_req) begin
                  r_halt_pending <= 1'b1;
               end
               if (imem_ack) begin
                  r_instr_out   <= imem_rdata;
                  r_instr_addr  <= r_pc;
                  r_instr_valid <= 1'b1;
                  r_pc          <= r_pc + 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= OUT;
               end
            end
            OUT: begin
               if (instr_ready) begin
                  r_instr_valid <= 1'b0;
                  if (r_halt_pending || halt_req) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else if (branch_valid) begin
                     r_pc        <= branch_target;
                     r_imem_req  <= 1'b1;
                     r_imem_addr <= branch_target;
                     r_state     <= REQ;
                  end else if (r_instr_addr == end_addr) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_imem_req  <= 1'b1;
                     r_imem_addr <= r_pc;
                     r_state     <= REQ;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_imem_addr;
   assign instr_valid = r_instr_valid;
   assign instr_out   = r_instr_out;
   assign instr_addr  = r_instr_addr;
   assign busy        = r_busy;
   assign done        = r_done;

`ifdef FETCH_PERF_CNT_EN
   logic w_start_acc;
   logic w_handshake;

   assign w_start_acc = (r_state == IDLE) && start;
   assign w_handshake = (r_state == OUT) && instr_ready;

   fetch_sat_cnt #(.W(16)) u_fetch_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_start_acc),
      .i_inc   (w_handshake),
      .o_count (fetch_count)
   );
`else
   assign fetch_count = 16'h0000;
`endif

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, instruction word-address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin fetching at start_addr; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first word address to fetch.
REQ-007 end_addr  input  ADDR_W  last word address of the program.
REQ-008 halt_req  input  1  stop after the instruction currently in flight.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  ADDR_W  word address for the read.
REQ-011 imem_ack  input  1  read data valid; completes the request.
REQ-012 imem_rdata  input  DATA_W  read data, valid with imem_ack.
REQ-013 instr_valid  output  1  instr_out and instr_addr hold a valid instruction.
REQ-014 instr_ready  input  1  downstream accepts the instruction.
REQ-015 instr_out  output  DATA_W  fetched instruction.
REQ-016 instr_addr  output  ADDR_W  word address of instr_out.
REQ-017 branch_valid  input  1  redirect request from downstream.
REQ-018 branch_target  input  ADDR_W  redirect word address.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse when the sequence ends.
REQ-021 fetch_count  output  16  number of delivered instructions (see Configuration).

Function
REQ-022 The FSM SHALL have states IDLE, REQ, OUT and DONE.
REQ-023 IDLE: start=1 -> pc<=start_addr, halt_pending<=0, next state REQ.
REQ-024 REQ: imem_req=1 and imem_addr=pc, both held stable until the cycle in which imem_ack=1.
REQ-025 REQ with imem_ack=1: instr_out<=imem_rdata, instr_addr<=pc, instr_valid<=1, pc<=pc+1 (modulo 2^ADDR_W), next state OUT; the request is never withdrawn before ack.
REQ-026 imem_req SHALL deassert in the cycle after ack; back-to-back fetches therefore carry a minimum of 1 idle cycle per instruction plus the OUT handshake.
REQ-027 OUT: instr_valid, instr_out and instr_addr SHALL stay stable until instr_ready=1; on that handshake instr_valid<=0.
REQ-028 Next state on the OUT handshake, by priority: halt_pending or halt_req -> DONE; branch_valid -> pc<=branch_target, REQ; instr_addr==end_addr -> DONE; otherwise REQ.
REQ-029 branch_valid SHALL be ignored unless it coincides with the OUT handshake.
REQ-030 halt_req in REQ SHALL set halt_pending; the outstanding fetch completes and is delivered before DONE.
REQ-031 halt_req and start SHALL be ignored in IDLE and DONE respectively; start is ignored in every state other than IDLE.
REQ-032 DONE: done=1 for exactly one cycle, next state IDLE.
REQ-033 pc wrap from 2^ADDR_W-1 to 0 SHALL be silent; end_addr below start_addr SHALL be reached only after wrap.

Reset
REQ-034 On rst=1 the state SHALL become IDLE immediately, independent of clk.
REQ-035 Reset values: pc=0, halt_pending=0, imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_addr=0, busy=0, done=0, fetch_count=0.
REQ-036 Reset mid-fetch SHALL drop the outstanding request; a later imem_ack in IDLE SHALL be ignored.

Configuration
REQ-037 Macro FETCH_PERF_CNT_EN defined: fetch_count increments on every OUT handshake, saturates at 16'hFFFF, and clears on start accepted in IDLE.
REQ-038 Macro FETCH_PERF_CNT_EN undefined: fetch_count tied to 0 and no counter flops exist.

Structure
REQ-039 A package fetch_ctrl_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W defaults.
REQ-040 The saturating counter SHALL be a sub-module fetch_sat_cnt, instantiated only under FETCH_PERF_CNT_EN; all other logic stays in instr_fetch_ctrl.

Verification
REQ-041 start_addr=0x10, end_addr=0x12, imem_ack 1 cycle after req, instr_ready=1 -> 3 instructions with addresses 0x10,0x11,0x12, done pulse, fetch_count=3.
REQ-042 instr_ready held 0 for 5 cycles in OUT -> instr_out/instr_addr unchanged and no new imem_req until the handshake.
REQ-043 branch_valid=1, target 0x40 on the handshake of 0x11 -> next imem_addr=0x40, and end_addr 0x12 is not reached.
REQ-044 halt_req pulsed in REQ at 0x11 with ack delayed 3 cycles -> 0x11 delivered, then done; no fetch of 0x12.
REQ-045 start_addr=0xFF, end_addr=0x01 -> fetch sequence 0xFF,0x00,0x01, then done.
REQ-046 rst asserted mid-REQ then imem_ack=1 -> all outputs at reset values and no instr_valid.
